// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared encodings for the multiply/divide sequencer:
//             FSM state codes, operation types, exception codes and the
//             default watchdog limit.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Operation requested by the main control unit
  localparam logic [1:0] OP_MULT = 2'b00;  // A * B
  localparam logic [1:0] OP_DIV  = 2'b01;  // A / B
  localparam logic [1:0] OP_DIVM = 2'b10;  // memory data / memory out
  localparam logic [1:0] OP_ILL  = 2'b11;  // reserved, rejected

  // Exception codes reported alongside the exc pulse
  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_DIV0    = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL = 2'b11;

  // Default watchdog limit (cycles spent in WAIT); legal range 2..255
  localparam int unsigned DEF_TIMEOUT = 40;

  // True for both divide flavours, which share the Div unit
  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVM);
  endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : Sequencer for the shared Mult/Div resource. Accepts one op at a
//             time, pulses the unit start, steers the HI/LO input muxes,
//             raises the HI/LO write enables and reports completion or an
//             exception (divide-by-zero, watchdog timeout, illegal op).
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  // Maximum number of WAIT cycles before the watchdog fires (2..255)
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,            // synchronous, active-low
  // request side
  input  logic       op_valid,
  input  logic [1:0] op_type,
  output logic       op_ready,
  // Mult unit handshake
  output logic       mult_start,
  input  logic       mult_end,
  // Div unit handshake
  output logic       div_start,
  input  logic       div_end,
  input  logic       div_0_exception,
  // HI/LO datapath control
  output logic       div_src,
  output logic       div_or_mult,
  output logic       high_write,
  output logic       low_write,
  // completion / exception reporting
  output logic       done,
  output logic       exc,
  output logic [1:0] exc_code
);

  // Watchdog compare value; the counter is 8 bits and TIMEOUT <= 255, so it
  // never wraps before this value is reached.
  localparam logic [7:0] c_WD_LAST = 8'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t     r_state;
  logic [1:0] r_op;           // latched legal op (never OP_ILL)
  logic [7:0] r_wd;           // watchdog, counts WAIT cycles
  logic       r_div_src;
  logic       r_div_or_mult;
  logic       r_exc;
  logic [1:0] r_exc_code;
  logic       r_exc_hold;     // holds op_ready low during a WAIT exception pulse

  // --------------------------------------------------------------------------
  // Combinational next-state signals
  // --------------------------------------------------------------------------
  state_t     w_state_nxt;
  logic [7:0] w_wd_nxt;
  logic       w_accept;       // legal op taken in IDLE this cycle
  logic       w_illegal;      // illegal op presented in IDLE this cycle
  logic       w_wait_exc;     // exception detected while waiting
  logic [1:0] w_wait_code;
  logic       w_is_div;
  logic       w_unit_end;

  // Only the selected unit's handshakes matter; the other unit is ignored.
  assign w_is_div   = is_div_op(r_op);
  assign w_unit_end = w_is_div ? div_end : mult_end;

  // Next-state decode, watchdog update and exception detection
  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_accept    = 1'b0;
    w_illegal   = 1'b0;
    w_wait_exc  = 1'b0;
    w_wait_code = EXC_NONE;

    case (r_state)
      ST_IDLE: begin
        // Requests are taken only while op_ready is presented.
        if (op_valid && !r_exc_hold) begin
          if (op_type == OP_ILL) begin
            w_illegal = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_START;
          end
        end
      end

      ST_START: begin
        w_wd_nxt    = 8'd0;
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        // Divide-by-zero outranks a simultaneous div_end, and any end
        // handshake outranks the watchdog on its last cycle.
        if (w_is_div && div_0_exception) begin
          w_wait_exc  = 1'b1;
          w_wait_code = EXC_DIV0;
          w_state_nxt = ST_IDLE;
        end else if (w_unit_end) begin
          w_state_nxt = ST_WRITE;
        end else if (r_wd == c_WD_LAST) begin
          w_wait_exc  = 1'b1;
          w_wait_code = EXC_TIMEOUT;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wd_nxt = r_wd + 8'd1;
        end
      end

      ST_WRITE: w_state_nxt = ST_DONE;

      ST_DONE:  w_state_nxt = ST_IDLE;

      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and watchdog counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_wd    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

  // Latch the accepted op and its mux selects; selects hold in IDLE so the
  // HI/LO input muxes stay stable between operations.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_op          <= OP_MULT;
      r_div_src     <= 1'b0;
      r_div_or_mult <= 1'b0;
    end else if (w_accept) begin
      r_op          <= op_type;
      r_div_src     <= (op_type == OP_DIVM);
      r_div_or_mult <= (op_type == OP_MULT);
    end
  end

  // One-cycle exception pulse, code valid only while the pulse is high
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_exc      <= 1'b0;
      r_exc_code <= EXC_NONE;
      r_exc_hold <= 1'b0;
    end else begin
      r_exc      <= w_illegal | w_wait_exc;
      r_exc_hold <= w_wait_exc;
      if (w_illegal) begin
        r_exc_code <= EXC_ILLEGAL;
      end else if (w_wait_exc) begin
        r_exc_code <= w_wait_code;
      end else begin
        r_exc_code <= EXC_NONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: pulses decode straight from the registered state, so each is
  // exactly one cycle wide and returns to 0 on the edge reset is seen.
  // --------------------------------------------------------------------------
  assign op_ready    = (r_state == ST_IDLE) && !r_exc_hold;
  assign mult_start  = (r_state == ST_START) && !w_is_div;
  assign div_start   = (r_state == ST_START) &&  w_is_div;
  assign high_write  = (r_state == ST_WRITE);
  assign low_write   = (r_state == ST_WRITE);
  assign done        = (r_state == ST_DONE);
  assign exc         = r_exc;
  assign exc_code    = r_exc_code;
  assign div_src     = r_div_src;
  assign div_or_mult = r_div_or_mult;

endmodule : muldiv_ctrl
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Purpose  : Self-checking bench for muldiv_ctrl. Completion and exception
//             events are predicted into a queue when an op is issued and
//             matched (kind, code, cycle) when the DUT raises done/exc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

  localparam int unsigned TB_TIMEOUT = 8;

  logic       clock;
  logic       reset;
  logic       op_valid;
  logic [1:0] op_type;
  logic       op_ready;
  logic       mult_start;
  logic       mult_end;
  logic       div_start;
  logic       div_end;
  logic       div_0_exception;
  logic       div_src;
  logic       div_or_mult;
  logic       high_write;
  logic       low_write;
  logic       done;
  logic       exc;
  logic [1:0] exc_code;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit         is_exc;
    logic [1:0] code;
    int         at;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  muldiv_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_type        (op_type),
    .op_ready       (op_ready),
    .mult_start     (mult_start),
    .mult_end       (mult_end),
    .div_start      (div_start),
    .div_end        (div_end),
    .div_0_exception(div_0_exception),
    .div_src        (div_src),
    .div_or_mult    (div_or_mult),
    .high_write     (high_write),
    .low_write      (low_write),
    .done           (done),
    .exc            (exc),
    .exc_code       (exc_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every done/exc pulse must match the oldest prediction
  always @(negedge clock) begin
    if (reset && (done || exc)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got done=%b exc=%b code=%b at cycle %0d, none expected",
                 done, exc, exc_code, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({exc, done, exc_code} !== {mon_e.is_exc, !mon_e.is_exc, mon_e.code} || cyc != mon_e.at) begin
          errors++;
          $display("FAIL event_match: got exc=%b done=%b code=%b cycle %0d, want exc=%b done=%b code=%b cycle %0d",
                   exc, done, exc_code, cyc, mon_e.is_exc, !mon_e.is_exc, mon_e.code, mon_e.at);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_ev(input bit is_exc, input logic [1:0] code, input int at);
    ev_t e;
    e.is_exc = is_exc;
    e.code   = code;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [10:0] got;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clock);
      got = {op_ready, mult_start, div_start, high_write, low_write, done, exc, exc_code, div_src, div_or_mult};
      checks++;
      if (got !== 11'b100_0000_0000) begin
        errors++;
        $display("FAIL reset_values: got %b want %b", got, 11'b100_0000_0000);
      end
    end
    next_cycle();
    reset = 1'b1;
  endtask

  // MULT with mult_end in the third WAIT cycle
  task automatic test_mult();
    int c;
    logic [4:0] got, want;
    next_cycle();
    c = cyc;
    op_valid = 1'b1;
    op_type  = 2'b00;
    push_ev(1'b0, 2'b00, c + 6);
    for (int off = 1; off <= 7; off++) begin
      next_cycle();
      op_valid = 1'b0;
      mult_end = (off == 4);
      @(negedge clock);
      got  = {op_ready, mult_start, div_start, high_write, low_write};
      want = {off == 7, off == 1, 1'b0, off == 5, off == 5};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mult_ctrl off=%0d: got rdy/ms/ds/hw/lw=%b want %b", off, got, want);
      end
      checks++;
      if ({div_src, div_or_mult} !== 2'b01) begin
        errors++;
        $display("FAIL mult_selects off=%0d: got %b want 01", off, {div_src, div_or_mult});
      end
    end
    mult_end = 1'b0;
  endtask

  // DIVM with div_end in the first WAIT cycle: done 4 cycles after accept
  task automatic test_divm();
    int c;
    logic [4:0] got, want;
    next_cycle();
    c = cyc;
    op_valid = 1'b1;
    op_type  = 2'b10;
    push_ev(1'b0, 2'b00, c + 4);
    for (int off = 1; off <= 5; off++) begin
      next_cycle();
      op_valid = 1'b0;
      div_end  = (off == 2);
      @(negedge clock);
      got  = {op_ready, mult_start, div_start, high_write, low_write};
      want = {off == 5, 1'b0, off == 1, off == 3, off == 3};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL divm_ctrl off=%0d: got rdy/ms/ds/hw/lw=%b want %b", off, got, want);
      end
      checks++;
      if ({div_src, div_or_mult} !== 2'b10) begin
        errors++;
        $display("FAIL divm_selects off=%0d: got %b want 10", off, {div_src, div_or_mult});
      end
    end
    div_end = 1'b0;
  endtask

  // DIV with div_0_exception and div_end together: exception wins
  task automatic test_div0();
    int c;
    logic [4:0] got, want;
    next_cycle();
    c = cyc;
    op_valid = 1'b1;
    op_type  = 2'b01;
    push_ev(1'b1, 2'b01, c + 3);
    for (int off = 1; off <= 5; off++) begin
      next_cycle();
      op_valid        = 1'b0;
      div_end         = (off == 2);
      div_0_exception = (off == 2);
      @(negedge clock);
      got  = {op_ready, mult_start, div_start, high_write, low_write};
      want = {off >= 4, 1'b0, off == 1, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL div0_ctrl off=%0d: got rdy/ms/ds/hw/lw=%b want %b", off, got, want);
      end
      checks++;
      if (exc_code !== ((off == 3) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL div0_code off=%0d: got %b want %b", off, exc_code, (off == 3) ? 2'b01 : 2'b00);
      end
    end
    div_end         = 1'b0;
    div_0_exception = 1'b0;
  endtask

  // Illegal op rejected in IDLE, then a MULT presented back to back
  task automatic test_illegal_back_to_back();
    int c;
    logic [4:0] got, want;
    next_cycle();
    c = cyc;
    op_valid = 1'b1;
    op_type  = 2'b11;
    push_ev(1'b1, 2'b11, c + 1);
    push_ev(1'b0, 2'b00, c + 5);
    for (int off = 1; off <= 6; off++) begin
      next_cycle();
      if (off == 1) op_type = 2'b00;
      if (off == 2) op_valid = 1'b0;
      mult_end = (off == 3);
      @(negedge clock);
      got  = {op_ready, mult_start, div_start, high_write, low_write};
      want = {(off == 1) || (off == 6), off == 2, 1'b0, off == 4, off == 4};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL illegal_b2b_ctrl off=%0d: got rdy/ms/ds/hw/lw=%b want %b", off, got, want);
      end
      // After the prior DIV the selects sit at 00 until the MULT is taken
      checks++;
      if ({div_src, div_or_mult} !== ((off == 1) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL illegal_b2b_selects off=%0d: got %b want %b",
                 off, {div_src, div_or_mult}, (off == 1) ? 2'b00 : 2'b01);
      end
    end
    mult_end = 1'b0;
  endtask

  // MULT that never ends: watchdog fires after TB_TIMEOUT WAIT cycles,
  // spurious Div handshakes are ignored
  task automatic test_timeout();
    int c;
    logic [4:0] got, want;
    next_cycle();
    c = cyc;
    op_valid = 1'b1;
    op_type  = 2'b00;
    push_ev(1'b1, 2'b10, c + 2 + TB_TIMEOUT);
    for (int off = 1; off <= TB_TIMEOUT + 4; off++) begin
      next_cycle();
      op_valid        = 1'b0;
      div_end         = (off == 3) || (off == 5);
      div_0_exception = (off == 3);
      @(negedge clock);
      got  = {op_ready, mult_start, div_start, high_write, low_write};
      want = {off >= TB_TIMEOUT + 3, off == 1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout_ctrl off=%0d: got rdy/ms/ds/hw/lw=%b want %b", off, got, want);
      end
    end
    div_end         = 1'b0;
    div_0_exception = 1'b0;
  endtask

  // Reset asserted during WAIT, then a fresh DIV completes normally
  task automatic test_reset_mid_op();
    int c;
    logic [10:0] gotf;
    logic [4:0]  got, want;
    next_cycle();
    c = cyc;
    op_valid = 1'b1;
    op_type  = 2'b10;
    for (int off = 1; off <= 4; off++) begin
      next_cycle();
      op_valid = 1'b0;
      if (off == 3) reset = 1'b0;
      if (off == 4) reset = 1'b1;
      @(negedge clock);
      if (off == 1) begin
        checks++;
        if ({div_start, div_src, div_or_mult} !== 3'b110) begin
          errors++;
          $display("FAIL rstmid_start: got ds/src/dom=%b want 110", {div_start, div_src, div_or_mult});
        end
      end
      if (off == 4) begin
        gotf = {op_ready, mult_start, div_start, high_write, low_write, done, exc, exc_code, div_src, div_or_mult};
        checks++;
        if (gotf !== 11'b100_0000_0000) begin
          errors++;
          $display("FAIL rstmid_values: got %b want %b", gotf, 11'b100_0000_0000);
        end
      end
    end
    next_cycle();
    c = cyc;
    op_valid = 1'b1;
    op_type  = 2'b01;
    push_ev(1'b0, 2'b00, c + 5);
    for (int off = 1; off <= 6; off++) begin
      next_cycle();
      op_valid = 1'b0;
      div_end  = (off == 3);
      @(negedge clock);
      got  = {op_ready, mult_start, div_start, high_write, low_write};
      want = {off == 6, 1'b0, off == 1, off == 4, off == 4};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rstmid_div off=%0d: got rdy/ms/ds/hw/lw=%b want %b", off, got, want);
      end
      checks++;
      if ({div_src, div_or_mult} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_div_selects off=%0d: got %b want 00", off, {div_src, div_or_mult});
      end
    end
    div_end = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    op_valid        = 1'b0;
    op_type         = 2'b00;
    mult_end        = 1'b0;
    div_end         = 1'b0;
    div_0_exception = 1'b0;

    test_reset();
    test_mult();
    test_divm();
    test_div0();
    test_illegal_back_to_back();
    test_timeout();
    test_reset_mid_op();

    for (int i = 0; i < 3; i++) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_muldiv_ctrl
`default_nettype wire
